pipe_stage_hs: RTL
==================

// Module: pipe_stage_hs
// PURPOSE
//  Generic parametrised pipeline-stage register with valid/ready handshake, stall back-pressure and flush.
//  Replaces the fixed per-stage registers (decode->execute, execute->memory, memory->writeback) in the pipelined core.
//  Carries one control bundle, NUM_LANES data words and NUM_RADDR register-index fields per entry.
//  Flush inserts a bubble: valid and control are cleared; data is optionally cleared.
// PARAMETERS
//  DATA_WIDTH          32  width of each data lane (operands, PC, immediate, PC+4)
//  NUM_LANES           5   number of DATA_WIDTH lanes carried
//  REG_ADDR_WIDTH      5   width of each register-index field (rd, rs1, rs2)
//  NUM_RADDR           3   number of register-index fields carried
//  CTRL_WIDTH          11  width of the packed control bundle (pipe_pkg::ctrl_t)
//  ZERO_DATA_ON_FLUSH  1   1: flush/reset also zero data and index fields; 0: they hold their value
// PORTS
//  clk        in   1                        clock, rising edge
//  rst        in   1                        synchronous, active-high reset
//  flush      in   1                        squash the held entry and any entry accepted this cycle
//  in_valid   in   1                        upstream entry valid
//  in_ready   out  1                        stage can accept this cycle
//  in_ctrl    in   CTRL_WIDTH               upstream control bundle
//  in_data    in   NUM_LANES*DATA_WIDTH     upstream lanes; lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//  in_raddr   in   NUM_RADDR*REG_ADDR_WIDTH upstream register-index fields
//  out_valid  out  1                        downstream entry valid
//  out_ready  in   1                        downstream accepts this cycle (0 = stall)
//  out_ctrl   out  CTRL_WIDTH               registered control; all-zero whenever out_valid=0
//  out_data   out  NUM_LANES*DATA_WIDTH     registered lanes
//  out_raddr  out  NUM_RADDR*REG_ADDR_WIDTH registered index fields
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_ctrl=0; out_data/out_raddr=0 if ZERO_DATA_ON_FLUSH else unchanged; skid entry emptied.
//  - Accept = in_valid & in_ready; drain = out_valid & out_ready. Latency 1 clock from accept to out_valid.
//  - Entry never lost or duplicated: accepted entries appear on out_* exactly once, in order.
//  - out_* stable while out_valid=1 and out_ready=0 (hold).
//  - Priority: rst > flush > accept/drain.
//  - flush=1: next cycle out_valid=0, out_ctrl=0, skid emptied, accept this cycle discarded; in_ready unaffected.
//  - Invalid entries always present out_ctrl=0, so downstream reading ctrl without valid sees a bubble.
//  - Base (macro off): single slot. in_ready = ~out_valid | out_ready (combinational from out_ready).
//    Simultaneous drain+accept loads new entry; drain without accept -> out_valid=0.
// CONFIGURATION
//  - PIPE_SKID_EN defined: 2-entry skid buffer; in_ready is a pure register (no out_ready->in_ready path).
//    States EMPTY (no entry), ONE (main slot valid), FULL (main+skid valid); in_ready = (state != FULL).
//    EMPTY: accept -> ONE.
//    ONE: accept&~drain -> FULL (new entry to skid); accept&drain -> ONE (load main); ~accept&drain -> EMPTY.
//    FULL: drain -> ONE (skid moves to main, same cycle); no accept possible.
//    flush/rst in any state -> EMPTY.
//  - PIPE_SKID_EN undefined: single slot as above, no state register beyond out_valid.
// STRUCTURE
//  - pipe_pkg: ctrl_t packed struct (regwrite, resultsrc[1:0], memwrite, jump, branch, alucontrol[2:0], alusrc, jalr).
//    pipe_pkg also holds CTRL_WIDTH = $bits(ctrl_t) and skid_state_t enum {EMPTY, ONE, FULL}.
//  - Sub-module pipe_slot: one storage entry (valid, ctrl, data, raddr) with load and clear inputs.
//    One pipe_slot instance is used as main; a second is used as skid under PIPE_SKID_EN.
// TESTING
//  - Reset: drive rst=1 with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0; release -> entry 1 cycle after accept.
//  - Streaming: out_ready=1, 8 back-to-back entries data=0x100+i -> out_data lane0 = 0x100+i, one per cycle, no gaps.
//  - Stall: accept 0xA5, out_ready=0 for 4 cycles -> out_data held 0xA5.
//    Base: in_ready=0 while stalled. Skid: one more entry 0xA6 accepted, then in_ready=0; release -> 0xA5 then 0xA6.
//  - Flush: flush=1 with in_valid=1, ctrl=0x7FF -> next cycle out_valid=0, out_ctrl=0x000, out_data=0 (ZERO_DATA_ON_FLUSH=1).
//  - Flush in FULL (skid build): both entries dropped, state EMPTY, in_ready=1 next cycle.
//  - Random valid/ready scoreboard, 10k cycles, both macro settings: in-order, no loss or duplication, out_ctrl=0 when !out_valid.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipelined core's inter-stage registers.
package pipe_pkg;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic [2:0] alucontrol;
        logic       alusrc;
        logic       jalr;
    } ctrl_t;

    localparam int unsigned CTRL_WIDTH = $bits(ctrl_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage entry: valid, control, data lanes and register indices.
// Clear beats load; clear always drops valid/ctrl, and zeroes payload only when zero_i is set.
module pipe_slot #(
    parameter int unsigned CTRL_WIDTH         = 11,
    parameter int unsigned DATA_BITS          = 160,
    parameter int unsigned RADDR_BITS         = 15,
    parameter bit          ZERO_DATA_ON_FLUSH = 1'b1
) (
    input  logic                  clk,
    input  logic                  load_i,
    input  logic                  clr_i,
    input  logic                  zero_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_BITS-1:0]  data_i,
    input  logic [RADDR_BITS-1:0] raddr_i,
    output logic                  valid_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_BITS-1:0]  data_o,
    output logic [RADDR_BITS-1:0] raddr_o
);

    logic                  valid_q, valid_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [RADDR_BITS-1:0] raddr_q, raddr_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        raddr_d = raddr_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (zero_i && ZERO_DATA_ON_FLUSH) begin
                data_d  = '0;
                raddr_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
            raddr_d = raddr_i;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        ctrl_q  <= ctrl_d;
        data_q  <= data_d;
        raddr_q <= raddr_d;
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign raddr_o = raddr_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, stall and flush.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_hs #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned NUM_LANES          = 5,
    parameter int unsigned REG_ADDR_WIDTH     = 5,
    parameter int unsigned NUM_RADDR          = 3,
    parameter int unsigned CTRL_WIDTH         = pipe_pkg::CTRL_WIDTH,
    parameter bit          ZERO_DATA_ON_FLUSH = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CTRL_WIDTH-1:0]               in_ctrl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     in_data,
    input  logic [NUM_RADDR*REG_ADDR_WIDTH-1:0] in_raddr,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CTRL_WIDTH-1:0]               out_ctrl,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     out_data,
    output logic [NUM_RADDR*REG_ADDR_WIDTH-1:0] out_raddr
);

    import pipe_pkg::*;

    localparam int unsigned DATA_BITS  = NUM_LANES * DATA_WIDTH;
    localparam int unsigned RADDR_BITS = NUM_RADDR * REG_ADDR_WIDTH;

    logic                  accept, drain, squash;
    logic                  main_load, main_clr;
    logic [CTRL_WIDTH-1:0] main_ctrl_in;
    logic [DATA_BITS-1:0]  main_data_in;
    logic [RADDR_BITS-1:0] main_raddr_in;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;
    assign squash = rst | flush;

    pipe_slot #(
        .CTRL_WIDTH         (CTRL_WIDTH),
        .DATA_BITS          (DATA_BITS),
        .RADDR_BITS         (RADDR_BITS),
        .ZERO_DATA_ON_FLUSH (ZERO_DATA_ON_FLUSH)
    ) u_main (
        .clk     (clk),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .zero_i  (squash),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .raddr_i (main_raddr_in),
        .valid_o (out_valid),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data),
        .raddr_o (out_raddr)
    );

`ifdef PIPE_SKID_EN

    skid_state_t           state_q, state_d;
    logic                  in_ready_q;
    logic                  skid_load, skid_clr, skid_valid;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_BITS-1:0]  skid_data;
    logic [RADDR_BITS-1:0] skid_raddr;

    pipe_slot #(
        .CTRL_WIDTH         (CTRL_WIDTH),
        .DATA_BITS          (DATA_BITS),
        .RADDR_BITS         (RADDR_BITS),
        .ZERO_DATA_ON_FLUSH (ZERO_DATA_ON_FLUSH)
    ) u_skid (
        .clk     (clk),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .zero_i  (squash),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .raddr_i (in_raddr),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data),
        .raddr_o (skid_raddr)
    );

    // in_ready is derived from the next state so it carries no out_ready path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = FULL;
                    else if (!accept && drain) state_d = EMPTY;
                end
                FULL:    if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load     = 1'b0;
        main_clr      = squash;
        skid_load     = 1'b0;
        skid_clr      = squash;
        main_ctrl_in  = in_ctrl;
        main_data_in  = in_data;
        main_raddr_in = in_raddr;
        unique case (state_q)
            EMPTY: main_load = accept;
            ONE: begin
                main_load = accept & drain;
                skid_load = accept & ~drain;
                main_clr  = squash | (drain & ~accept);
            end
            FULL: begin
                main_ctrl_in  = skid_ctrl;
                main_data_in  = skid_data;
                main_raddr_in = skid_raddr;
                main_load     = drain;
                skid_clr      = squash | drain;
            end
            default: main_clr = 1'b1;
        endcase
    end

    assign in_ready = in_ready_q;

    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

`else

    assign in_ready      = ~out_valid | out_ready;
    assign main_load     = accept;
    assign main_clr      = squash | (drain & ~accept);
    assign main_ctrl_in  = in_ctrl;
    assign main_data_in  = in_data;
    assign main_raddr_in = in_raddr;

`endif

endmodule
